// File: rtl/level_meter_pkg.sv
// Shared types, widths and helpers for the output level meter.
// Widths cover a 15-bit peak scaled by 1000 and a 4-digit display.
`timescale 1ns/1ps
package level_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        BCD,
        UPDATE
    } state_e;

    localparam int NUM_W      = 25;
    localparam int DEN_W      = 15;
    localparam int QUO_W      = 14;
    localparam int DIV_CYCLES = 25;
    localparam int BCD_CYCLES = 14;

    // -32768 has no positive twin in 16 bits; pin it to 32767.
    function automatic logic [DEN_W-1:0] abs_sat16(input logic signed [15:0] x);
        if (x[15]) begin
            if (x[14:0] == '0) begin
                return '1;
            end
            return DEN_W'(-x);
        end
        return x[DEN_W-1:0];
    endfunction

    function automatic logic [15:0] bcd_step(input logic [15:0] b,
                                             input logic       s);
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
        end
        return 16'({a, s});
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Fixed latency: done_o is high during the last iteration cycle.
`timescale 1ns/1ps
module seq_divider
    import level_meter_pkg::*;
#(
    parameter int NW     = NUM_W,
    parameter int DW     = DEN_W,
    parameter int CYCLES = DIV_CYCLES
) (
    input  logic          clk_48,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic          done_o,
    output logic [NW-1:0] quo_o,
    output logic          div_by_zero_o
);

    localparam int CNT_W = $clog2(CYCLES);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NW-1:0]    quo_q, quo_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    den_q, den_d;
    logic             dbz_q, dbz_d;

    logic [DW:0]      trial;
    logic             fits;
    logic             last;

    assign trial = {rem_q, quo_q[NW-1]};
    assign fits  = trial >= {1'b0, den_q};
    assign last  = cnt_q == CNT_W'(CYCLES - 1);

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        den_d = den_q;
        dbz_d = dbz_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = num_i;
            rem_d = '0;
            den_d = den_i;
            dbz_d = den_i == '0;
        end else if (run_q) begin
            // A zero divisor idles the shifter but keeps the cycle count.
            if (!dbz_q) begin
                quo_d = {quo_q[NW-2:0], fits};
                rem_d = fits ? DW'(trial - {1'b0, den_q}) : trial[DW-1:0];
            end
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            den_q <= den_d;
            dbz_q <= dbz_d;
        end
    end

    assign done_o        = run_q && last;
    assign quo_o         = quo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: rtl/level_meter_ctrl.sv
// Windowed peak tracker feeding a shared divider and serial BCD stage.
// Produces 1000*out_peak/in_peak for the 4-digit seven-segment display.
`timescale 1ns/1ps
module level_meter_ctrl
    import level_meter_pkg::*;
#(
    parameter int unsigned SAMPLES  = 12000,
    parameter int unsigned SCALE    = 1000,
    parameter int unsigned MAX_DISP = 9999
) (
    input  logic               clk_48,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic signed [15:0] in_wave,
    input  logic signed [15:0] out_wave,
    input  logic               hold,
    output logic [3:0]         num3,
    output logic [3:0]         num2,
    output logic [3:0]         num1,
    output logic [3:0]         num0,
    output logic               ratio_valid,
    output logic               overflow,
    output logic               overrun,
    output logic               busy
);

    logic [15:0]      cnt_q, cnt_d;
    logic [DEN_W-1:0] in_pk_q, in_pk_d;
    logic [DEN_W-1:0] out_pk_q, out_pk_d;
    logic [DEN_W-1:0] in_snap_q, in_snap_d;
    logic [DEN_W-1:0] out_snap_q, out_snap_d;
    logic             win_end_q, win_end_d;

    state_e           state_q, state_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [QUO_W-1:0] bin_q, bin_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      dig_q, dig_d;
    logic             rv_q, rv_d;
    logic             overflow_q, overflow_d;
    logic             overrun_q, overrun_d;

    logic [DEN_W-1:0] in_mag, out_mag;
    logic [DEN_W-1:0] in_max, out_max;
    logic             div_start;
    logic [NUM_W-1:0] div_num;
    logic             div_done;
    logic [NUM_W-1:0] div_quo;
    logic             div_dbz;
    logic             ovf_now;
    logic [QUO_W-1:0] qclamp;
    logic [15:0]      src_bcd;
    logic [QUO_W-1:0] src_bin;

    assign in_mag  = abs_sat16(in_wave);
    assign out_mag = abs_sat16(out_wave);
    assign in_max  = (in_mag > in_pk_q) ? in_mag : in_pk_q;
    assign out_max = (out_mag > out_pk_q) ? out_mag : out_pk_q;

    always_comb begin
        cnt_d      = cnt_q;
        in_pk_d    = in_pk_q;
        out_pk_d   = out_pk_q;
        in_snap_d  = in_snap_q;
        out_snap_d = out_snap_q;
        win_end_d  = 1'b0;
        if (sample_valid) begin
            if (cnt_q == 16'(SAMPLES - 1)) begin
                cnt_d      = '0;
                in_pk_d    = '0;
                out_pk_d   = '0;
                in_snap_d  = in_max;
                out_snap_d = out_max;
                win_end_d  = 1'b1;
            end else begin
                cnt_d    = cnt_q + 16'd1;
                in_pk_d  = in_max;
                out_pk_d = out_max;
            end
        end
    end

    assign div_start = (state_q == IDLE) && win_end_q;
    assign div_num   = NUM_W'(SCALE) * NUM_W'(out_snap_q);

    seq_divider #(
        .NW     (NUM_W),
        .DW     (DEN_W),
        .CYCLES (DIV_CYCLES)
    ) u_div (
        .clk_48        (clk_48),
        .reset_n       (reset_n),
        .start_i       (div_start),
        .num_i         (div_num),
        .den_i         (in_snap_q),
        .done_o        (div_done),
        .quo_o         (div_quo),
        .div_by_zero_o (div_dbz)
    );

    assign ovf_now = div_dbz || (div_quo > NUM_W'(MAX_DISP));
    assign qclamp  = ovf_now ? QUO_W'(MAX_DISP) : div_quo[QUO_W-1:0];

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        ovf_d      = ovf_q;
        dig_d      = dig_q;
        rv_d       = 1'b0;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        src_bcd    = bcd_q;
        src_bin    = bin_q;
        if (win_end_q && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (win_end_q) begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d = BCD;
                    bcnt_d  = '0;
                end
            end
            BCD: begin
                // First step loads the clamped quotient and shifts at once.
                if (bcnt_q == '0) begin
                    src_bcd = '0;
                    src_bin = qclamp;
                    ovf_d   = ovf_now;
                end
                bcd_d  = bcd_step(src_bcd, src_bin[QUO_W-1]);
                bin_d  = src_bin << 1;
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == 4'(BCD_CYCLES - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                rv_d       = 1'b1;
                overflow_d = ovf_q;
                if (!hold) begin
                    dig_d = bcd_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            in_pk_q    <= '0;
            out_pk_q   <= '0;
            in_snap_q  <= '0;
            out_snap_q <= '0;
            win_end_q  <= 1'b0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
            rv_q       <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            in_pk_q    <= in_pk_d;
            out_pk_q   <= out_pk_d;
            in_snap_q  <= in_snap_d;
            out_snap_q <= out_snap_d;
            win_end_q  <= win_end_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
            rv_q       <= rv_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
        end
    end

    assign num3        = dig_q[15:12];
    assign num2        = dig_q[11:8];
    assign num1        = dig_q[7:4];
    assign num0        = dig_q[3:0];
    assign ratio_valid = rv_q;
    assign overflow    = overflow_q;
    assign overrun     = overrun_q;
    assign busy        = state_q != IDLE;

endmodule

// File: tb/tb_level_meter_ctrl.sv
// Randomised self-checking bench for level_meter_ctrl (SAMPLES=64).
// A second instance with a short window exercises the overrun path.
`timescale 1ns/1ps
module tb_level_meter_ctrl;

    logic               clk_48 = 1'b0;
    logic               reset_n;
    logic               sample_valid;
    logic               sv2;
    logic signed [15:0] in_wave;
    logic signed [15:0] out_wave;
    logic               hold;
    logic [3:0]         num3, num2, num1, num0;
    logic               ratio_valid, overflow, overrun, busy;
    logic [3:0]         n3b, n2b, n1b, n0b;
    logic               rv2, ovf2, ovr2, busy2;

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_dig = '0;

    always #5 clk_48 = ~clk_48;

    level_meter_ctrl #(.SAMPLES(64)) dut (
        .clk_48       (clk_48),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .in_wave      (in_wave),
        .out_wave     (out_wave),
        .hold         (hold),
        .num3         (num3),
        .num2         (num2),
        .num1         (num1),
        .num0         (num0),
        .ratio_valid  (ratio_valid),
        .overflow     (overflow),
        .overrun      (overrun),
        .busy         (busy)
    );

    level_meter_ctrl #(.SAMPLES(32)) dut_short (
        .clk_48       (clk_48),
        .reset_n      (reset_n),
        .sample_valid (sv2),
        .in_wave      (in_wave),
        .out_wave     (out_wave),
        .hold         (hold),
        .num3         (n3b),
        .num2         (n2b),
        .num1         (n1b),
        .num0         (n0b),
        .ratio_valid  (rv2),
        .overflow     (ovf2),
        .overrun      (ovr2),
        .busy         (busy2)
    );

    function automatic int mag(input int x);
        int m;
        m = (x < 0) ? -x : x;
        return (m > 32767) ? 32767 : m;
    endfunction

    function automatic int model_ratio(input int ip, input int op);
        int r;
        if (ip == 0) return 9999;
        r = (1000 * op) / ip;
        return (r > 9999) ? 9999 : r;
    endfunction

    function automatic logic model_ovf(input int ip, input int op);
        if (ip == 0) return 1'b1;
        return ((1000 * op) / ip) > 9999;
    endfunction

    function automatic logic [15:0] bcd_of(input int r);
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic int rnd_below(input int pk);
        int v;
        v = int'($urandom_range(0, mag(pk)));
        return ($urandom_range(0, 1) == 1) ? -v : v;
    endfunction

    task automatic step();
        @(posedge clk_48);
        #1;
    endtask

    task automatic run_window(input int ipk, input int opk, input bit gaps,
                              output int pin, output int pout);
        int p, a, b;
        p    = $urandom_range(0, 63);
        pin  = 0;
        pout = 0;
        for (int i = 0; i < 64; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sample_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            a = (i == p) ? ipk : rnd_below(ipk);
            b = (i == p) ? opk : rnd_below(opk);
            sample_valid = 1'b1;
            in_wave      = 16'(a);
            out_wave     = 16'(b);
            if (mag(a) > pin) pin = mag(a);
            if (mag(b) > pout) pout = mag(b);
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic measure(output int lat, output logic busy1,
                           output logic [15:0] dig, output logic ovf,
                           output logic rv_after);
        lat   = 0;
        busy1 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 1) busy1 = busy;
            if (ratio_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        dig = {num3, num2, num1, num0};
        ovf = overflow;
        step();
        rv_after = ratio_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_valid = 1'b0; sv2 = 1'b0;
        in_wave = '0; out_wave = '0; hold = 1'b0;
        repeat (3) step();
        total++;
        if ({num3, num2, num1, num0, ratio_valid, overflow, overrun, busy} !== 20'h0)
            $display("FAIL reset_in: got %h want 0",
                     {num3, num2, num1, num0, ratio_valid, overflow, overrun, busy});
        else passed++;
        reset_n = 1'b1;
        repeat (2) step();
        total++;
        if ({num3, num2, num1, num0, ratio_valid, overflow, overrun, busy} !== 20'h0)
            $display("FAIL reset_after: got %h want 0",
                     {num3, num2, num1, num0, ratio_valid, overflow, overrun, busy});
        else passed++;
    endtask

    task automatic test_table(input string nm, input int n,
                              input int ipks[4], input int opks[4],
                              input bit hv[4], input bit gaps);
        int pin, pout, lat;
        logic b1, ov, rva;
        logic [15:0] dg;
        for (int w = 0; w < n; w++) begin
            hold = hv[w];
            run_window(ipks[w], opks[w], gaps, pin, pout);
            measure(lat, b1, dg, ov, rva);
            hold = 1'b0;
            if (!hv[w]) exp_dig = bcd_of(model_ratio(pin, pout));
            total++;
            if (lat != 41) $display("FAIL %s_latency[%0d]: got %0d want 41", nm, w, lat);
            else passed++;
            total++;
            if (dg !== exp_dig) $display("FAIL %s_digits[%0d]: got %h want %h", nm, w, dg, exp_dig);
            else passed++;
            total++;
            if (ov !== model_ovf(pin, pout))
                $display("FAIL %s_overflow[%0d]: got %b want %b", nm, w, ov, model_ovf(pin, pout));
            else passed++;
            total++;
            if ({b1, rva} !== 2'b10)
                $display("FAIL %s_busy_pulse[%0d]: got %b want 10", nm, w, {b1, rva});
            else passed++;
        end
    endtask

    task automatic test_basic();
        test_table("basic", 1, '{1000, 0, 0, 0}, '{500, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
    endtask

    task automatic test_sign_sat();
        test_table("sign_sat", 2, '{-2000, -32768, 0, 0}, '{2000, 32767, 0, 0},
                   '{0, 0, 0, 0}, 1'b1);
    endtask

    task automatic test_zero_in();
        test_table("zero_in", 2, '{0, 300, 0, 0}, '{100, 300, 0, 0}, '{0, 0, 0, 0}, 1'b0);
    endtask

    task automatic test_clamp();
        test_table("clamp", 2, '{1, 7, 0, 0}, '{32767, 3, 0, 0}, '{0, 0, 0, 0}, 1'b0);
    endtask

    task automatic test_hold();
        test_table("hold", 2, '{0, 1000, 0, 0}, '{5, 500, 0, 0}, '{1, 0, 0, 0}, 1'b0);
    endtask

    task automatic test_random();
        int ip[4], op[4];
        for (int w = 0; w < 4; w++) begin
            ip[w] = (w == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 32767));
            op[w] = int'($urandom_range(0, 32767));
            if (w == 2) ip[w] = -32768;
            else if ($urandom_range(0, 1) == 1) ip[w] = -ip[w];
            if ($urandom_range(0, 1) == 1) op[w] = -op[w];
        end
        test_table("random", 4, ip, op, '{0, 0, 0, 0}, 1'b1);
    endtask

    task automatic test_back_to_back();
        int ip, op, n, a, b;
        int due[$];
        logic [15:0] dq[$];
        logic exp_rv;
        ip = 0; op = 0; n = 0;
        for (int s = 0; s < 192 + 50; s++) begin
            exp_rv = (due.size() > 0) && (due[0] == s);
            total++;
            if (ratio_valid !== exp_rv)
                $display("FAIL b2b_rv[%0d]: got %b want %b", s, ratio_valid, exp_rv);
            else passed++;
            if (exp_rv) begin
                exp_dig = dq.pop_front();
                void'(due.pop_front());
                total++;
                if ({num3, num2, num1, num0} !== exp_dig)
                    $display("FAIL b2b_digits[%0d]: got %h want %h", s,
                             {num3, num2, num1, num0}, exp_dig);
                else passed++;
            end
            if (s < 192) begin
                a = int'($urandom_range(0, 65535)) - 32768;
                b = int'($urandom_range(0, 65535)) - 32768;
                sample_valid = 1'b1;
                in_wave  = 16'(a);
                out_wave = 16'(b);
                if (mag(a) > ip) ip = mag(a);
                if (mag(b) > op) op = mag(b);
                n++;
                if (n == 64) begin
                    due.push_back(s + 42);
                    dq.push_back(bcd_of(model_ratio(ip, op)));
                    ip = 0; op = 0; n = 0;
                end
            end else begin
                sample_valid = 1'b0;
            end
            step();
        end
        total++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pin, pout, lat, seen;
        logic b1, ov, rva;
        logic [15:0] dg;
        run_window(1000, 500, 1'b0, pin, pout);
        for (int i = 0; i < 8; i++) begin
            sample_valid = (i < 5);
            in_wave  = 16'sd20000;
            out_wave = 16'sd20000;
            step();
        end
        sample_valid = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL reset_mid_busy: got %b want 1", busy);
        else passed++;
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({num3, num2, num1, num0, ratio_valid, overflow, overrun, busy} !== 20'h0)
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {num3, num2, num1, num0, ratio_valid, overflow, overrun, busy});
        else passed++;
        #2 reset_n = 1'b1;
        exp_dig = '0;
        step();
        seen = 0;
        in_wave  = 16'sd1000;
        out_wave = 16'sd250;
        for (int i = 0; i < 63 + 50; i++) begin
            sample_valid = (i < 63);
            step();
            if (ratio_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL reset_mid_early_result: got %0d pulses want 0", seen);
        else passed++;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        measure(lat, b1, dg, ov, rva);
        exp_dig = bcd_of(model_ratio(1000, 250));
        total++;
        if (lat != 41) $display("FAIL reset_mid_latency: got %0d want 41", lat);
        else passed++;
        total++;
        if ({dg, ov} !== {exp_dig, 1'b0})
            $display("FAIL reset_mid_result: got %h/%b want %h/0", dg, ov, exp_dig);
        else passed++;
    endtask

    task automatic test_overrun();
        int pulses;
        logic [15:0] d2;
        pulses = 0;
        d2 = '0;
        total++;
        if (ovr2 !== 1'b0) $display("FAIL overrun_initial: got %b want 0", ovr2);
        else passed++;
        in_wave  = 16'sd400;
        out_wave = 16'sd100;
        for (int s = 0; s < 96 + 50; s++) begin
            sv2 = (s < 96);
            step();
            if (s == 60) begin
                total++;
                if (ovr2 !== 1'b0) $display("FAIL overrun_early: got %b want 0", ovr2);
                else passed++;
            end
            if (rv2 === 1'b1) begin
                pulses++;
                d2 = {n3b, n2b, n1b, n0b};
            end
        end
        sv2 = 1'b0;
        total++;
        if (pulses != 2) $display("FAIL overrun_pulses: got %0d want 2", pulses);
        else passed++;
        total++;
        if (ovr2 !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", ovr2);
        else passed++;
        total++;
        if (d2 !== bcd_of(model_ratio(400, 100)))
            $display("FAIL overrun_digits: got %h want %h", d2, bcd_of(model_ratio(400, 100)));
        else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL overrun_main: got %b want 0", overrun);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_sat();
        test_zero_in();
        test_clamp();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_overrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
